// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init-table sequencer: entry opcodes,
// entry field positions and the sequencer state encoding.
package lcd_pkg;

   localparam logic [1:0] OP_CMD = 2'b00;
   localparam logic [1:0] OP_DAT = 2'b01;
   localparam logic [1:0] OP_DLY = 2'b10;
   localparam logic [1:0] OP_END = 2'b11;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 14;
   localparam int PAY_MSB = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_SEND,
      ST_WAIT,
      ST_NEXT,
      ST_FINISH
   } lcd_state_e;

endpackage

// File: rtl/lcd_ms_timer.sv
// Millisecond delay timer: a prescaler counting clock cycles inside one ms
// and an 8-bit ms down-counter that steps each time the prescaler wraps.
// expired is asserted in the last cycle of the last ms, so a caller that
// leaves on expired spends exactly ms_in * CLK_PER_MS cycles counting.
module lcd_ms_timer
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] ms_in,
   output logic       expired
);

   localparam int unsigned      PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_PER_MS - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    ms_q, ms_d;
   logic          wrap;

   assign wrap    = en && (pre_q == PRE_LAST);
   assign expired = wrap && (ms_q == 8'd1);

   // Next-state: load restarts the ms period; otherwise count while enabled.
   always_comb begin
      pre_d = pre_q;
      ms_d  = ms_q;
      if (load) begin
         pre_d = '0;
         ms_d  = ms_in;
      end else if (en) begin
         if (wrap) begin
            pre_d = '0;
            if (ms_q != 8'd0) begin
               ms_d = ms_q - 8'd1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else begin
         pre_q <= pre_d;
         ms_q  <= ms_d;
      end
   end

endmodule

// File: rtl/lcd_init_sequencer.sv
// Walks the LCD init-data ROM from address 0, turning each entry into a
// command write, data write, millisecond delay or end-of-table, then
// hands the bus back to the printer path.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus belongs to the printer; waiting for start
// FETCH  | address held one cycle so a synchronous ROM can respond
// DECODE | ROM word captured and opcode dispatched
// SEND   | byte offered to the writer until wr_valid && wr_ready
// WAIT   | delay entry counting down in the ms timer
// NEXT   | advance address, or finish after the last table slot
// FINISH | done pulse, busy low, back to IDLE
module lcd_init_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CLK_PER_MS = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic                  wr_dc,
   output logic [7:0]            wr_byte,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   lcd_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  dc_q, dc_d;
   logic [7:0]            byte_q, byte_d;

   logic [1:0] op;
   logic [7:0] pay;
   logic       tmr_load;
   logic       tmr_en;
   logic       tmr_expired;
   logic       unused_rom;

   // Bits [13:8] and anything above bit 15 carry no meaning.
   assign op         = rom_data[OP_MSB:OP_LSB];
   assign pay        = rom_data[PAY_MSB:0];
   assign unused_rom = ^rom_data;

   assign tmr_en   = (state_q == ST_WAIT);
   assign rom_addr = addr_q;
   assign wr_valid = (state_q == ST_SEND);
   assign wr_dc    = dc_q;
   assign wr_byte  = byte_q;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
   assign done     = (state_q == ST_FINISH);

   lcd_ms_timer #(
      .CLK_PER_MS (CLK_PER_MS)
   ) u_ms_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .en      (tmr_en),
      .ms_in   (pay),
      .expired (tmr_expired)
   );

   // Next-state and datapath decode.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      dc_d     = dc_q;
      byte_d   = byte_q;
      tmr_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (op)
               OP_CMD, OP_DAT: begin
                  dc_d    = (op == OP_DAT);
                  byte_d  = pay;
                  state_d = ST_SEND;
               end
               OP_DLY: begin
                  // Timer is reloaded even for a zero delay so no stale count survives.
                  tmr_load = 1'b1;
                  state_d  = (pay != '0) ? ST_WAIT : ST_NEXT;
               end
               default: begin
                  state_d = ST_FINISH;
               end
            endcase
         end
         ST_SEND: begin
            if (wr_ready) begin
               state_d = ST_NEXT;
            end
         end
         ST_WAIT: begin
            if (tmr_expired) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // A table without END stops at the last slot instead of wrapping.
            if (addr_q == ADDR_LAST) begin
               state_d = ST_FINISH;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, address and write-payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         dc_q    <= 1'b0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dc_q    <= dc_d;
         byte_q  <= byte_d;
      end
   end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Self-checking bench for lcd_init_sequencer. A synchronous ROM model feeds
// the DUT; a table-walking reference model predicts the transfer list, the
// busy length and the cycle of the first write from the entry rules.
module tb_lcd_init_sequencer;

   localparam int AW    = 7;
   localparam int DEPTH = 128;
   localparam int C     = 10;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic          wr_ready = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [15:0]   rom_data = '0;
   logic          wr_valid;
   logic          wr_dc;
   logic [7:0]    wr_byte;
   logic          busy;
   logic          done;

   logic [15:0] rom_mem [DEPTH];

   int checks = 0;
   int errors = 0;

   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   int busy_cyc, done_cnt, first_valid, stall_viol, max_addr, last_addr;
   bit wrapped, timed_out, busy_at_done;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   lcd_init_sequencer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (16),
      .CLK_PER_MS (C)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_dc    (wr_dc),
      .wr_byte  (wr_byte),
      .busy     (busy),
      .done     (done)
   );

   task automatic clear_table();
      for (int a = 0; a < DEPTH; a++) rom_mem[a] = 16'hC000;
   endtask

   // Reference: walk the table by its rules. Writes cost fetch+decode+send+next
   // plus forced stall cycles, delays cost fetch+decode+next plus n ms, END
   // costs fetch+decode, running off the last slot simply stops.
   task automatic model_table(input int stall_n, output int busy_exp, output int first_exp);
      int cyc;
      logic [1:0] op;
      logic [7:0] pay;
      cyc = 0;
      first_exp = -1;
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++) begin
         op  = rom_mem[a][15:14];
         pay = rom_mem[a][7:0];
         if (op == 2'b11) begin
            cyc += 2;
            break;
         end else if (op == 2'b10) begin
            cyc += 3 + int'(pay) * C;
         end else begin
            if (first_exp < 0) first_exp = cyc + 3;
            exp_q.push_back({(op == 2'b01), pay});
            cyc += 4 + stall_n;
         end
      end
      busy_exp = cyc;
   endtask

   // Pulses start and observes one run until done (or the cycle limit).
   // Called and returns at posedge+1.
   task automatic run_table(input int ready_pct, input int stall_n, input int repulse_at, input int limit);
      int t, vrun;
      bit pv, pr;
      logic pdc;
      logic [7:0] pb;
      logic [AW-1:0] pa;
      got_q.delete();
      busy_cyc = 0; done_cnt = 0; first_valid = -1; stall_viol = 0;
      max_addr = 0; last_addr = -1; wrapped = 0; timed_out = 0; busy_at_done = 0;
      start = 1'b1;
      wr_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      t = 1; vrun = 0; pv = 0; pr = 0; pdc = 1'b0; pb = '0; pa = rom_addr;
      forever begin
         start = (t == repulse_at);
         if (wr_valid) begin
            wr_ready = (vrun >= stall_n) && ($urandom_range(99, 0) < ready_pct);
            vrun++;
         end else begin
            wr_ready = 1'($urandom_range(1, 0));
            vrun = 0;
         end
         if (pv && !pr && (!wr_valid || wr_dc !== pdc || wr_byte !== pb)) stall_viol++;
         if (wr_valid && wr_ready) got_q.push_back({wr_dc, wr_byte});
         if (wr_valid && first_valid < 0) first_valid = t;
         if (busy) busy_cyc++;
         if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
         if (pa == '1 && rom_addr == '0) wrapped = 1;
         if (done) begin
            done_cnt++;
            busy_at_done = busy;
            last_addr = int'(rom_addr);
         end
         pv = wr_valid; pr = wr_ready; pdc = wr_dc; pb = wr_byte; pa = rom_addr;
         if (done) break;
         if (t >= limit) begin
            timed_out = 1;
            break;
         end
         @(posedge clk); #1;
         t++;
      end
      start = 1'b0;
      wr_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
         if (busy) busy_cyc++;
      end
   endtask

   task automatic test_reset();
      checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
      checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
      checks++; if (wr_dc !== 1'b0) begin errors++; $display("FAIL reset_wr_dc got %b want 0", wr_dc); end
      checks++; if (wr_byte !== 8'h00) begin errors++; $display("FAIL reset_wr_byte got %h want 00", wr_byte); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({busy, done, wr_valid} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b want 000", {busy, done, wr_valid}); end
   endtask

   task automatic test_cmd_end();
      int bexp, fexp, nbad;
      clear_table();
      rom_mem[0] = 16'h0011;
      model_table(0, bexp, fexp);
      run_table(100, 0, 0, 200);
      checks++; if (timed_out) begin errors++; $display("FAIL cmd_timeout got timeout want done"); end
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL cmd_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL cmd_busy_len got %0d want %0d", busy_cyc, bexp); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL cmd_done_pulses got %0d want 1", done_cnt); end
      checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL cmd_busy_at_done got %b want 0", busy_at_done); end
      checks++; if (first_valid != fexp) begin errors++; $display("FAIL cmd_first_valid got %0d want %0d", first_valid, fexp); end
   endtask

   task automatic test_stall();
      int bexp, fexp, nbad;
      clear_table();
      rom_mem[0] = 16'h4055;
      model_table(10, bexp, fexp);
      run_table(100, 10, 0, 200);
      checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got timeout want done"); end
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL stall_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability got %0d changes want 0", stall_viol); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL stall_busy_len got %0d want %0d", busy_cyc, bexp); end
   endtask

   task automatic test_delay();
      int bexp, fexp, nbad;
      clear_table();
      rom_mem[0] = 16'h8003;
      rom_mem[1] = 16'h0029;
      model_table(0, bexp, fexp);
      run_table(100, 0, 0, 500);
      checks++; if (timed_out) begin errors++; $display("FAIL delay_timeout got timeout want done"); end
      checks++; if (first_valid != fexp) begin errors++; $display("FAIL delay3_first_valid got %0d want %0d", first_valid, fexp); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL delay3_busy_len got %0d want %0d", busy_cyc, bexp); end
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL delay3_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      rom_mem[0] = 16'h8000;
      model_table(0, bexp, fexp);
      run_table(100, 0, 0, 500);
      checks++; if (first_valid != fexp) begin errors++; $display("FAIL delay0_first_valid got %0d want %0d", first_valid, fexp); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL delay0_busy_len got %0d want %0d", busy_cyc, bexp); end
   endtask

   task automatic test_no_end();
      int bexp, fexp, nbad;
      for (int a = 0; a < DEPTH; a++) rom_mem[a] = 16'h4000 | 16'($urandom_range(16'h3FFF, 0));
      model_table(0, bexp, fexp);
      run_table(100, 0, 0, 2000);
      checks++; if (timed_out) begin errors++; $display("FAIL noend_timeout got timeout want done"); end
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL noend_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      checks++; if (max_addr != DEPTH - 1) begin errors++; $display("FAIL noend_max_addr got %0d want %0d", max_addr, DEPTH - 1); end
      checks++; if (last_addr != DEPTH - 1) begin errors++; $display("FAIL noend_addr_at_done got %0d want %0d", last_addr, DEPTH - 1); end
      checks++; if (wrapped) begin errors++; $display("FAIL noend_wrap got wrap to 0 want none"); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL noend_busy_len got %0d want %0d", busy_cyc, bexp); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL noend_done_pulses got %0d want 1", done_cnt); end
   endtask

   task automatic test_restart();
      int bexp, fexp, nbad;
      clear_table();
      for (int a = 0; a < 5; a++) rom_mem[a] = {1'b0, 1'($urandom_range(1, 0)), 6'h00, 8'($urandom)};
      model_table(0, bexp, fexp);
      run_table(100, 0, 4, 300);
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL repulse_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL repulse_busy_len got %0d want %0d", busy_cyc, bexp); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL repulse_done_pulses got %0d want 1", done_cnt); end
      run_table(60, 0, 0, 400);
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL replay_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL replay_done_pulses got %0d want 1", done_cnt); end
   endtask

   task automatic test_random();
      int bexp, fexp, nbad, len, pct;
      logic [1:0] op;
      logic [7:0] pay;
      for (int it = 0; it < 8; it++) begin
         clear_table();
         len = $urandom_range(12, 1);
         for (int a = 0; a < len; a++) begin
            op  = 2'($urandom_range(2, 0));
            pay = (op == 2'b10) ? 8'($urandom_range(2, 0)) : 8'($urandom);
            rom_mem[a] = {op, 6'($urandom), pay};
         end
         pct = (it % 2 == 0) ? 100 : 50;
         model_table(0, bexp, fexp);
         run_table(pct, 0, 0, 1000);
         checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout got timeout want done", it); end
         nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
         checks++; if (nbad != 0) begin errors++; $display("FAIL rand%0d_xfers got %0d xfers (%0d bad) want %0d", it, got_q.size(), nbad, exp_q.size()); end
         if (pct == 100) begin
            checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL rand%0d_busy_len got %0d want %0d", it, busy_cyc, bexp); end
         end
      end
   endtask

   task automatic test_async_reset();
      int bexp, fexp, nbad;
      // Interrupt a delay at address 1, after a data byte left wr_dc/wr_byte non-zero.
      clear_table();
      rom_mem[0] = 16'h4001;
      rom_mem[1] = 16'h8005;
      wr_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      checks++; if ({busy, wr_valid, rom_addr} !== {1'b1, 1'b0, 7'd1}) begin errors++; $display("FAIL wait_precond got busy=%b valid=%b addr=%0d want 1 0 1", busy, wr_valid, rom_addr); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({rom_addr, wr_valid, wr_dc, wr_byte, busy, done} !== '0) begin errors++; $display("FAIL wait_reset_outputs got %h want 0", {rom_addr, wr_valid, wr_dc, wr_byte, busy, done}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      // Interrupt a stalled data write at address 1.
      clear_table();
      rom_mem[0] = 16'h0010;
      rom_mem[1] = 16'h40A5;
      start = 1'b1;
      wr_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 2; t <= 9; t++) begin
         @(posedge clk); #1;
         if (t >= 5) wr_ready = 1'b0;
      end
      checks++; if ({wr_valid, wr_dc, wr_byte} !== {1'b1, 1'b1, 8'hA5}) begin errors++; $display("FAIL send_precond got %b want 1_1_10100101", {wr_valid, wr_dc, wr_byte}); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({rom_addr, wr_valid, wr_dc, wr_byte, busy, done} !== '0) begin errors++; $display("FAIL send_reset_outputs got %h want 0", {rom_addr, wr_valid, wr_dc, wr_byte, busy, done}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      // Clean run afterwards starts from address 0.
      clear_table();
      rom_mem[0] = 16'h0029;
      model_table(0, bexp, fexp);
      run_table(100, 0, 0, 200);
      nbad = (got_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) nbad++;
      checks++; if (nbad != 0) begin errors++; $display("FAIL post_reset_xfers got %0d xfers (%0d bad) want %0d", got_q.size(), nbad, exp_q.size()); end
      checks++; if (first_valid != fexp) begin errors++; $display("FAIL post_reset_first_valid got %0d want %0d", first_valid, fexp); end
      checks++; if (busy_cyc != bexp) begin errors++; $display("FAIL post_reset_busy_len got %0d want %0d", busy_cyc, bexp); end
   endtask

   initial begin
      clear_table();
      rst_n = 1'b0;
      start = 1'b0;
      wr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_cmd_end();
      test_stall();
      test_delay();
      test_no_end();
      test_restart();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish want finish before 1 ms sim time");
      $fatal(1, "watchdog expired");
   end

endmodule
